// File: rtl/pc_gen.sv
// pc_gen: instruction-fetch address generator.
// Produces the registered fetch address (pc) and instruction-memory enable
// (ce). The redirect priority is flush, then stall, then live branch, then
// pending branch, then sequential increment. A branch resolved during a stall
// is held in a one-entry latch, so it is not lost.
module pc_gen #(
  parameter int                    ADDR_WIDTH   = 32,
  parameter int                    INST_BYTES   = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0,
  parameter int                    STALL_WIDTH  = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [STALL_WIDTH-1:0] stall,
  input  logic                   flush_i,
  input  logic [ADDR_WIDTH-1:0]  new_pc_i,
  input  logic                   branch_flag_i,
  input  logic [ADDR_WIDTH-1:0]  branch_target_address_i,
  output logic [ADDR_WIDTH-1:0]  pc,
  output logic                   ce,
  output logic                   pc_misaligned_o,
  output logic                   branch_pending_o
);

  // Sequential step, sized to the address so that the sum wraps naturally.
  localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(INST_BYTES);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  state_e                  state_q;
  state_e                  state_d;
  logic [ADDR_WIDTH-1:0]   pc_q;
  logic [ADDR_WIDTH-1:0]   pc_d;
  logic                    pending_q;
  logic                    pending_d;
  logic [ADDR_WIDTH-1:0]   pend_target_q;
  logic [ADDR_WIDTH-1:0]   pend_target_d;
  logic                    stall_pc;

  // Only the lowest stall bit concerns the PC. The upper bits belong to later
  // pipeline stages and are deliberately left unused.
  assign stall_pc = stall[0];

  generate
    if (STALL_WIDTH > 1) begin : g_stall_unused
      logic unused_stall_bits;
      assign unused_stall_bits = ^stall[STALL_WIDTH-1:1];
    end
  endgenerate

  // State register: reset forces IDLE immediately, without waiting for a clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: leave IDLE on the first edge with reset low. RUN exits only through reset.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = S_RUN;
      S_RUN:   state_d = S_RUN;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic: ce comes straight from the state register, so it is registered.
  always_comb begin
    ce = 1'b0;
    case (state_q)
      S_IDLE:  ce = 1'b0;
      S_RUN:   ce = 1'b1;
      default: ce = 1'b0;
    endcase
  end

  // Next-PC selection and pending-latch update, in redirect priority order.
  always_comb begin
    pc_d          = pc_q;
    pending_d     = pending_q;
    pend_target_d = pend_target_q;
    if (state_q == S_IDLE) begin
      // While idle, hold the reset vector and ignore all redirect requests.
      pc_d          = RESET_VECTOR;
      pending_d     = 1'b0;
      pend_target_d = pend_target_q;
    end else if (flush_i) begin
      // An exception or eret overrides everything, including a stall.
      pc_d      = new_pc_i;
      pending_d = 1'b0;
    end else if (stall_pc) begin
      // Hold the fetch. Remember the most recent branch seen during the stall.
      pc_d = pc_q;
      if (branch_flag_i) begin
        pend_target_d = branch_target_address_i;
        pending_d     = 1'b1;
      end
    end else if (branch_flag_i) begin
      // A live branch is newer than anything latched, so it wins.
      pc_d      = branch_target_address_i;
      pending_d = 1'b0;
    end else if (pending_q) begin
      // The stall has ended. Take the branch that arrived while stalled.
      pc_d      = pend_target_q;
      pending_d = 1'b0;
    end else begin
      pc_d = pc_q + PC_STEP;
    end
  end

  // PC and pending-latch registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q          <= RESET_VECTOR;
      pending_q     <= 1'b0;
      pend_target_q <= '0;
    end else begin
      pc_q          <= pc_d;
      pending_q     <= pending_d;
      pend_target_q <= pend_target_d;
    end
  end

  assign pc               = pc_q;
  assign branch_pending_o = pending_q;

  // The misalignment flag is derived from the next PC and registered with it,
  // so it always describes the address currently being fetched.
  generate
    if (INST_BYTES > 1) begin : g_align
      localparam int LSB_W = $clog2(INST_BYTES);
      logic misaligned_d;
      logic misaligned_q;

      assign misaligned_d = (state_d == S_RUN) && (pc_d[LSB_W-1:0] != '0);

      // Misalignment flag register, cleared by reset together with ce.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          misaligned_q <= 1'b0;
        end else begin
          misaligned_q <= misaligned_d;
        end
      end

      assign pc_misaligned_o = misaligned_q;
    end else begin : g_no_align
      // With byte-sized instructions, every address is aligned.
      assign pc_misaligned_o = 1'b0;
    end
  endgenerate

endmodule

// File: tb/tb_pc_gen.sv
// Directed testbench for pc_gen. The main instance uses the default
// parameters. The second instance uses a 16-bit address with a high reset
// vector, so that wrap and misalignment can be checked.
module tb_pc_gen;

  logic        clk;
  logic        rst;
  logic [5:0]  stall;
  logic        flush_i;
  logic [31:0] new_pc_i;
  logic        branch_flag_i;
  logic [31:0] branch_target_address_i;
  logic [31:0] pc;
  logic        ce;
  logic        pc_misaligned_o;
  logic        branch_pending_o;

  logic        rst2;
  logic [5:0]  stall2;
  logic        flush2;
  logic [15:0] new_pc2;
  logic        branch2;
  logic [15:0] target2;
  logic [15:0] pc2;
  logic        ce2;
  logic        mis2;
  logic        pend2;

  int vectors;
  int miscompares;

  pc_gen dut (
    .clk                     (clk),
    .rst                     (rst),
    .stall                   (stall),
    .flush_i                 (flush_i),
    .new_pc_i                (new_pc_i),
    .branch_flag_i           (branch_flag_i),
    .branch_target_address_i (branch_target_address_i),
    .pc                      (pc),
    .ce                      (ce),
    .pc_misaligned_o         (pc_misaligned_o),
    .branch_pending_o        (branch_pending_o)
  );

  pc_gen #(
    .ADDR_WIDTH   (16),
    .INST_BYTES   (4),
    .RESET_VECTOR (16'hFFF8),
    .STALL_WIDTH  (6)
  ) dut16 (
    .clk                     (clk),
    .rst                     (rst2),
    .stall                   (stall2),
    .flush_i                 (flush2),
    .new_pc_i                (new_pc2),
    .branch_flag_i           (branch2),
    .branch_target_address_i (target2),
    .pc                      (pc2),
    .ce                      (ce2),
    .pc_misaligned_o         (mis2),
    .branch_pending_o        (pend2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock edge. Inputs are driven and outputs sampled 1 ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Compare the main instance's outputs with the expected values.
  task automatic expect_main(input string name, input logic [31:0] exp_pc,
                             input logic exp_ce, input logic exp_pend,
                             input logic exp_mis);
    vectors++;
    if (pc !== exp_pc) begin
      miscompares++;
      $display("FAIL %s pc: got %h expected %h", name, pc, exp_pc);
    end
    if (ce !== exp_ce) begin
      miscompares++;
      $display("FAIL %s ce: got %b expected %b", name, ce, exp_ce);
    end
    if (branch_pending_o !== exp_pend) begin
      miscompares++;
      $display("FAIL %s pending: got %b expected %b", name, branch_pending_o, exp_pend);
    end
    if (pc_misaligned_o !== exp_mis) begin
      miscompares++;
      $display("FAIL %s misaligned: got %b expected %b", name, pc_misaligned_o, exp_mis);
    end
    $display("vec %0d %s: pc=%h ce=%b pend=%b mis=%b", vectors, name, pc, ce,
             branch_pending_o, pc_misaligned_o);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    expect_main("reset_held", 32'h0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    #2;
    expect_main("reset_released_before_edge", 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_run();
    step();
    expect_main("run_first_edge", 32'h0, 1'b1, 1'b0, 1'b0);
    step();
    expect_main("run_inc4", 32'h4, 1'b1, 1'b0, 1'b0);
    step();
    expect_main("run_inc8", 32'h8, 1'b1, 1'b0, 1'b0);
    step();
    expect_main("run_incC", 32'hC, 1'b1, 1'b0, 1'b0);
    step();
    expect_main("run_inc10", 32'h10, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_stalled_branch();
    stall = 6'h01;
    step();
    expect_main("stall_c1", 32'h10, 1'b1, 1'b0, 1'b0);
    branch_flag_i = 1'b1;
    branch_target_address_i = 32'h200;
    step();
    expect_main("stall_c2_branch", 32'h10, 1'b1, 1'b1, 1'b0);
    branch_flag_i = 1'b0;
    branch_target_address_i = 32'h0;
    step();
    expect_main("stall_c3", 32'h10, 1'b1, 1'b1, 1'b0);
    stall = 6'h00;
    step();
    expect_main("pending_taken", 32'h200, 1'b1, 1'b0, 1'b0);
    step();
    expect_main("after_pending", 32'h204, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_flush_priority();
    stall = 6'h01;
    branch_flag_i = 1'b1;
    branch_target_address_i = 32'h80;
    step();
    expect_main("flush_setup_pending", 32'h204, 1'b1, 1'b1, 1'b0);
    flush_i = 1'b1;
    new_pc_i = 32'hBFC00380;
    branch_target_address_i = 32'h40;
    step();
    expect_main("flush_wins", 32'hBFC00380, 1'b1, 1'b0, 1'b0);
    flush_i = 1'b0;
    branch_flag_i = 1'b0;
    stall = 6'h00;
    step();
    expect_main("after_flush", 32'hBFC00384, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_override();
    stall = 6'h01;
    branch_flag_i = 1'b1;
    branch_target_address_i = 32'h100;
    step();
    expect_main("override_setup", 32'hBFC00384, 1'b1, 1'b1, 1'b0);
    stall = 6'h00;
    branch_target_address_i = 32'h300;
    step();
    expect_main("live_branch_wins", 32'h300, 1'b1, 1'b0, 1'b0);
    branch_flag_i = 1'b0;
    step();
    expect_main("stale_pending_dropped", 32'h304, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_async_reset();
    branch_flag_i = 1'b1;
    branch_target_address_i = 32'h44;
    step();
    expect_main("areset_goto44", 32'h44, 1'b1, 1'b0, 1'b0);
    stall = 6'h01;
    branch_target_address_i = 32'h100;
    step();
    expect_main("areset_pending", 32'h44, 1'b1, 1'b1, 1'b0);
    branch_flag_i = 1'b0;
    stall = 6'h00;
    #2;
    rst = 1'b1;
    #1;
    expect_main("areset_immediate", 32'h0, 1'b0, 1'b0, 1'b0);
    step();
    rst = 1'b0;
    #1;
    expect_main("areset_released", 32'h0, 1'b0, 1'b0, 1'b0);
    step();
    expect_main("areset_rerun", 32'h0, 1'b1, 1'b0, 1'b0);
    step();
    expect_main("areset_inc", 32'h4, 1'b1, 1'b0, 1'b0);
  endtask

  // Compare the 16-bit instance's outputs with the expected values.
  task automatic test_wrap_misalign();
    logic [15:0] exp_pc [5];
    logic        exp_mis [5];
    exp_pc[0] = 16'hFFF8; exp_mis[0] = 1'b0;
    exp_pc[1] = 16'hFFFC; exp_mis[1] = 1'b0;
    exp_pc[2] = 16'h0000; exp_mis[2] = 1'b0;
    exp_pc[3] = 16'h0102; exp_mis[3] = 1'b1;
    exp_pc[4] = 16'h0106; exp_mis[4] = 1'b1;
    rst2 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      branch2 = (i == 3);
      target2 = (i == 3) ? 16'h0102 : 16'h0000;
      step();
      vectors++;
      if (pc2 !== exp_pc[i] || ce2 !== 1'b1 || mis2 !== exp_mis[i] || pend2 !== 1'b0) begin
        miscompares++;
        $display("FAIL wrap_%0d: got pc=%h ce=%b mis=%b pend=%b expected pc=%h ce=1 mis=%b pend=0",
                 i, pc2, ce2, mis2, pend2, exp_pc[i], exp_mis[i]);
      end
      $display("vec %0d wrap_%0d: pc=%h ce=%b mis=%b", vectors, i, pc2, ce2, mis2);
    end
    branch2 = 1'b0;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b1;
    stall = '0;
    flush_i = 1'b0;
    new_pc_i = '0;
    branch_flag_i = 1'b0;
    branch_target_address_i = '0;
    rst2 = 1'b1;
    stall2 = '0;
    flush2 = 1'b0;
    new_pc2 = '0;
    branch2 = 1'b0;
    target2 = '0;

    test_reset();
    test_run();
    test_stalled_branch();
    test_flush_priority();
    test_override();
    test_async_reset();
    test_wrap_misalign();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised fetch-address generator for the OpenMIPS instruction-fetch stage, the successor to the fixed 32-bit PC register. It produces the instruction-memory address `pc` and chip-enable `ce`, and advances `pc` by one instruction per unstalled cycle. It adds a configurable reset vector, a pipeline-flush redirect with top priority, and a pending-branch latch so a branch resolved during a fetch stall is not lost. It sits between the control/stall unit, the ID-stage branch logic and the instruction ROM.

## Interface
- `ADDR_WIDTH`, 32: width of `pc` and of all target addresses.
- `INST_BYTES`, 4: PC increment per instruction; power of two, at least 1.
- `RESET_VECTOR`, 32'h0000_0000: value `pc` holds while `ce` is low.
- `STALL_WIDTH`, 6: width of the stall vector; only bit 0 is used.

- `clk`, input, 1: clock; all state changes on the rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `stall`, input, STALL_WIDTH: stall vector; `stall[0]`=1 freezes the PC.
- `flush_i`, input, 1: pipeline flush (exception or eret).
- `new_pc_i`, input, ADDR_WIDTH: redirect address, used when `flush_i`=1.
- `branch_flag_i`, input, 1: a taken branch/jump is resolved this cycle.
- `branch_target_address_i`, input, ADDR_WIDTH: branch target.
- `pc`, output, ADDR_WIDTH: fetch address (registered).
- `ce`, output, 1: instruction-memory enable (registered).
- `pc_misaligned_o`, output, 1: registered; high while `pc[log2(INST_BYTES)-1:0]`≠0 and `ce`=1. Tied 0 when `INST_BYTES`=1.
- `branch_pending_o`, output, 1: pending-branch latch is valid (registered).

## Operation
- Reset is asynchronous, active-high, and applies immediately. Reset values: `ce`=0, `pc`=RESET_VECTOR, `pc_misaligned_o`=0, `branch_pending_o`=0, pending target=0.
- States:
  - IDLE: `ce`=0. Entered on reset.
  - RUN: `ce`=1.
  - IDLE→RUN on the first rising edge with `rst`=0.
  - There is no RUN→IDLE transition except through `rst`.
- In IDLE, `pc` holds RESET_VECTOR. Flush, branch and stall inputs are ignored and the pending latch stays clear.
- In RUN, the next-`pc` priority per edge is:
  1. `flush_i`=1: `pc`←`new_pc_i`; clear the pending latch. This applies even when `stall[0]`=1.
  2. `stall[0]`=1: `pc` holds. If `branch_flag_i`=1, latch the target and set pending. A later branch during the same stall overwrites the latched target.
  3. `branch_flag_i`=1: `pc`←`branch_target_address_i`; clear pending. A live branch beats an older pending one.
  4. Pending set: `pc`←latched target; clear pending.
  5. Otherwise: `pc`←`pc`+INST_BYTES, modulo 2^ADDR_WIDTH, so all-ones wraps to low addresses with no flag.
- Targets load unmodified even if misaligned. `pc_misaligned_o` is computed from the next-`pc` value and registered together with `pc`. The exception unit consumes it; this block does not trap.

## Timing
- `ce` rises exactly one edge after `rst` deasserts. The first increment happens on the following edge, so `pc`=RESET_VECTOR for at least one cycle with `ce`=1.
- Redirect latency: flush or branch asserted in cycle N gives the new `pc` visible in cycle N+1.
- Pending latency: a branch during a stall gives the target in the cycle after `stall[0]` falls, with no sequential fetch in between.
- Simultaneous events:
  - Flush with branch: flush wins and the branch is dropped.
  - Flush with pending: pending is cleared.
  - Branch with pending, unstalled: the live target wins.
- `rst` asserted mid-operation, at any point including with a pending branch: all state returns to reset values immediately, and IDLE→RUN repeats.

## Test plan
- Reset and run (defaults): release `rst` → `ce`=0 until the first edge, then 1. `pc` sequence 0,0,4,8,C…
- Stalled branch: `stall[0]`=1 for 3 cycles at `pc`=0x10 with a branch to 0x200 in the second stall cycle. Required: `branch_pending_o`=1, `pc` holds 0x10, then `pc`=0x200 on the first unstalled edge, then 0x204.
- Flush priority: `stall[0]`=1 with a pending branch to 0x80, then `flush_i`=1 with `new_pc_i`=0xBFC00380 in the same cycle as `branch_flag_i`=1 to 0x40. Required: `pc`=0xBFC00380, pending cleared.
- Wrap and misalign (ADDR_WIDTH=16, RESET_VECTOR=16'hFFF8): `pc` goes FFF8, FFFC, 0000. A branch to 0x0102 gives `pc`=0x0102 with `pc_misaligned_o`=1, then 0x0106 with `pc_misaligned_o` still 1.
- Async reset mid-run: assert `rst` between edges while `pc`=0x44 with pending set. Required: immediately `ce`=0, `pc`=RESET_VECTOR, `branch_pending_o`=0.
- Override: branch to 0x300 while pending 0x100 and unstalled → `pc`=0x300, pending cleared.
